// File: rtl/vote_tally_pkg.sv
// ---------------------------------------------------------------------------
// vote_tally_pkg
//   Shared types and width helpers for the vote tally sequencer.
//
//   Contents:
//     vote_state_e  : session state (IDLE / COLLECT / REPORT)
//     CMP_W         : width used for the majority / tie comparison
//     count_width() : bits needed to hold the values 0..max_val
//
//   Optional feature macro used by the design: VOTE_TALLY_TIE_FLAG_EN
// ---------------------------------------------------------------------------
package vote_tally_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } vote_state_e;

  // Largest product in the comparison is 15 voters * 255 rounds = 3825, and
  // the doubled yes total reaches at most 7650, so 16 bits leave headroom.
  localparam int unsigned CMP_W = 16;

  // Bits needed to represent every value from 0 up to max_val inclusive.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// ---------------------------------------------------------------------------
// vote_popcount
//   Purely combinational yes-counter for one ballot.
//
//   Parameters:
//     N_VOTERS : number of ballot bits
//     CNT_W    : width of the binary count (holds 0..N_VOTERS)
//   Ports:
//     ballot [N_VOTERS-1:0] in  : one bit per voter, 1 = yes
//     onehot [N_VOTERS:0]   out : bit k set when exactly k voters said yes
//     count  [CNT_W-1:0]    out : binary number of yes votes
// ---------------------------------------------------------------------------
module vote_popcount #(
  parameter int N_VOTERS = 3,
  parameter int CNT_W    = 2
) (
  input  logic [N_VOTERS-1:0] ballot,
  output logic [N_VOTERS:0]   onehot,
  output logic [CNT_W-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      count = count + CNT_W'(ballot[i]);
    end
  end

  // Decoded by comparison rather than by indexing with count, so exactly one
  // bit is set for every legal count and no index can run past N_VOTERS.
  always_comb begin
    onehot = '0;
    for (int k = 0; k <= N_VOTERS; k++) begin
      onehot[k] = (count == CNT_W'(k));
    end
  end

endmodule

// File: rtl/vote_tally_seq.sv
// ---------------------------------------------------------------------------
// vote_tally_seq
//   Collects ballots over a session, accumulates yes votes and reports a
//   majority decision with a one-cycle result pulse.
//
//   Optional feature: define VOTE_TALLY_TIE_FLAG_EN to add the tie output.
//
//   Parameters:
//     N_VOTERS   : voters per ballot (1..15)
//     MAX_ROUNDS : ballots per session before the session closes itself
//   Ports:
//     clk, rst (sync, active-high)
//     start        in  : open a session (only honoured in IDLE)
//     close        in  : end the session (only honoured in COLLECT)
//     ballot_valid in  : ballot offered
//     ballot       in  : one bit per voter
//     ballot_ready out : ballot can be taken this cycle
//     round_onehot out : one-hot yes-count of the last accepted ballot
//     round_count  out : binary yes-count of the last accepted ballot
//     total_yes    out : yes votes accumulated this session
//     rounds       out : ballots accepted this session
//     busy         out : session open (COLLECT or REPORT)
//     result_valid out : one-cycle pulse while in REPORT
//     majority     out : decision, held until the next start
//     tie          out : exact tie, held until the next start (optional)
//     state_dbg    out : current FSM state
//
//   Handshake: a ballot is taken on a rising edge where ballot_valid and
//   ballot_ready are both high; ballot_ready depends only on the state, never
//   on ballot_valid, and the offer may be withdrawn at any time.
// ---------------------------------------------------------------------------
module vote_tally_seq
  import vote_tally_pkg::*;
#(
  parameter  int N_VOTERS   = 3,
  parameter  int MAX_ROUNDS = 8,
  localparam int CNT_W      = count_width(N_VOTERS),
  localparam int TOT_W      = count_width(N_VOTERS * MAX_ROUNDS),
  localparam int RND_W      = count_width(MAX_ROUNDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                close,
  input  logic                ballot_valid,
  input  logic [N_VOTERS-1:0] ballot,
  output logic                ballot_ready,
  output logic [N_VOTERS:0]   round_onehot,
  output logic [CNT_W-1:0]    round_count,
  output logic [TOT_W-1:0]    total_yes,
  output logic [RND_W-1:0]    rounds,
  output logic                busy,
  output logic                result_valid,
  output logic                majority,
`ifdef VOTE_TALLY_TIE_FLAG_EN
  output logic                tie,
`endif
  output vote_state_e         state_dbg
);

  localparam logic [N_VOTERS:0] ONEHOT_ZERO = {{N_VOTERS{1'b0}}, 1'b1};

  vote_state_e          state;
  logic [N_VOTERS:0]    pop_onehot;
  logic [CNT_W-1:0]     pop_count;
  logic                 accept;
  logic [TOT_W-1:0]     total_next;
  logic [RND_W-1:0]     rounds_next;
  logic                 at_limit;
  logic [CMP_W-1:0]     cmp_lhs;
  logic [CMP_W-1:0]     cmp_rhs;
  logic                 maj_next;
`ifdef VOTE_TALLY_TIE_FLAG_EN
  logic                 tie_next;
`endif

  assign state_dbg = state;
  assign accept    = ballot_valid & ballot_ready;

  vote_popcount #(
    .N_VOTERS (N_VOTERS),
    .CNT_W    (CNT_W)
  ) u_popcount (
    .ballot (ballot),
    .onehot (pop_onehot),
    .count  (pop_count)
  );

  // Totals as they will stand after this edge. The decision is computed from
  // these so a ballot accepted together with close (or the ballot that hits
  // MAX_ROUNDS) is part of the reported result.
  always_comb begin
    total_next  = total_yes;
    rounds_next = rounds;
    if (accept) begin
      total_next  = total_yes + TOT_W'(pop_count);
      rounds_next = rounds + RND_W'(1);
    end
    at_limit = (rounds_next == RND_W'(MAX_ROUNDS));
  end

  // Majority when yes votes exceed half of all votes cast:
  // 2*total_yes > N_VOTERS*rounds, evaluated in CMP_W bits. With zero rounds
  // both sides are zero, so majority is 0 without a special case.
  always_comb begin
    cmp_lhs  = CMP_W'(total_next) << 1;
    cmp_rhs  = CMP_W'(N_VOTERS) * CMP_W'(rounds_next);
    maj_next = (cmp_lhs > cmp_rhs);
`ifdef VOTE_TALLY_TIE_FLAG_EN
    tie_next = (cmp_lhs == cmp_rhs) && (rounds_next != '0);
`endif
  end

  // ballot_ready and busy are registered alongside state so they come
  // straight from flops and always agree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ballot_ready <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      majority     <= 1'b0;
      round_onehot <= ONEHOT_ZERO;
      round_count  <= '0;
      total_yes    <= '0;
      rounds       <= '0;
`ifdef VOTE_TALLY_TIE_FLAG_EN
      tie          <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            state        <= ST_COLLECT;
            ballot_ready <= 1'b1;
            busy         <= 1'b1;
            majority     <= 1'b0;
            round_onehot <= ONEHOT_ZERO;
            round_count  <= '0;
            total_yes    <= '0;
            rounds       <= '0;
`ifdef VOTE_TALLY_TIE_FLAG_EN
            tie          <= 1'b0;
`endif
          end
        end

        ST_COLLECT: begin
          if (accept) begin
            round_onehot <= pop_onehot;
            round_count  <= pop_count;
            total_yes    <= total_next;
            rounds       <= rounds_next;
          end
          if (close || (accept && at_limit)) begin
            state        <= ST_REPORT;
            ballot_ready <= 1'b0;
            result_valid <= 1'b1;
            majority     <= maj_next;
`ifdef VOTE_TALLY_TIE_FLAG_EN
            tie          <= tie_next;
`endif
          end
        end

        ST_REPORT: begin
          state        <= ST_IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end

        default: begin
          state        <= ST_IDLE;
          ballot_ready <= 1'b0;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_tally_seq.sv
// ---------------------------------------------------------------------------
// tb_vote_tally_seq
//   Directed bench for vote_tally_seq (N_VOTERS=3, MAX_ROUNDS=4). A session
//   model (list of per-ballot yes counts) predicts every output each cycle;
//   literal expectations after each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_vote_tally_seq;
  import vote_tally_pkg::*;

  localparam int NV = 3;
  localparam int MR = 4;
  localparam int CW = 2;
  localparam int TW = 4;
  localparam int RW = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          close = 1'b0;
  logic          ballot_valid = 1'b0;
  logic [NV-1:0] ballot = '0;

  logic          ballot_ready;
  logic [NV:0]   round_onehot;
  logic [CW-1:0] round_count;
  logic [TW-1:0] total_yes;
  logic [RW-1:0] rounds;
  logic          busy;
  logic          result_valid;
  logic          majority;
`ifdef VOTE_TALLY_TIE_FLAG_EN
  logic          tie;
`endif
  vote_state_e   state_dbg;

  always #5 clk = ~clk;

  vote_tally_seq #(
    .N_VOTERS   (NV),
    .MAX_ROUNDS (MR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .close        (close),
    .ballot_valid (ballot_valid),
    .ballot       (ballot),
    .ballot_ready (ballot_ready),
    .round_onehot (round_onehot),
    .round_count  (round_count),
    .total_yes    (total_yes),
    .rounds       (rounds),
    .busy         (busy),
    .result_valid (result_valid),
    .majority     (majority),
`ifdef VOTE_TALLY_TIE_FLAG_EN
    .tie          (tie),
`endif
    .state_dbg    (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- session model ----------------
  // m_open: 0 = no session, 1 = taking ballots, 2 = reporting this cycle
  int m_open = 0;
  int m_votes[$];
  int m_last = 0;
  int m_s = 0;
  bit m_maj = 1'b0;
  bit m_tie = 1'b0;

  function automatic int m_sum();
    int s;
    s = 0;
    foreach (m_votes[i]) s += m_votes[i];
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_open = 0;
      m_votes.delete();
      m_last = 0;
      m_maj  = 1'b0;
      m_tie  = 1'b0;
    end else if (m_open == 0) begin
      if (start) begin
        m_open = 1;
        m_votes.delete();
        m_last = 0;
        m_maj  = 1'b0;
        m_tie  = 1'b0;
      end
    end else if (m_open == 1) begin
      if (ballot_valid) begin
        m_last = $countones(ballot);
        m_votes.push_back(m_last);
      end
      if (close || m_votes.size() == MR) begin
        m_s    = m_sum();
        m_maj  = (2 * m_s > NV * m_votes.size());
        m_tie  = (2 * m_s == NV * m_votes.size()) && (m_votes.size() != 0);
        m_open = 2;
      end
    end else begin
      m_open = 0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("round_onehot", 32'(round_onehot), 32'(1) << m_last);
      chk("round_count",  32'(round_count),  32'(m_last));
      chk("total_yes",    32'(total_yes),    32'(m_sum()));
      chk("rounds",       32'(rounds),       32'(m_votes.size()));
      chk("busy",         32'(busy),         32'(m_open != 0));
      chk("ballot_ready", 32'(ballot_ready), 32'(m_open == 1));
      chk("result_valid", 32'(result_valid), 32'(m_open == 2));
      chk("majority",     32'(majority),     32'(m_maj));
`ifdef VOTE_TALLY_TIE_FLAG_EN
      chk("tie",          32'(tie),          32'(m_tie));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit s, input bit c, input bit v,
                       input logic [NV-1:0] b, input bit r);
    start        = s;
    close        = c;
    ballot_valid = v;
    ballot       = b;
    rst          = r;
    @(posedge clk);
    #2;
    start        = 1'b0;
    close        = 1'b0;
    ballot_valid = 1'b0;
    ballot       = '0;
    rst          = 1'b0;
  endtask

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
    $finish;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    // reset held two cycles
    rst = 1'b1;
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_onehot", 32'(round_onehot), 32'h1);
    chk("rst_total",  32'(total_yes),    32'h0);
    chk("rst_rounds", 32'(rounds),       32'h0);
    chk("rst_busy",   32'(busy),         32'h0);
    chk("rst_ready",  32'(ballot_ready), 32'h0);
    chk("rst_rv",     32'(result_valid), 32'h0);
    chk("rst_maj",    32'(majority),     32'h0);
    rst = 1'b0;
    drive(0, 0, 0, '0, 0);

    // 111, 000, 011 then close
    drive(1, 0, 0, '0, 0);
    chk("s1_ready", 32'(ballot_ready), 32'h1);
    drive(0, 0, 1, 3'b111, 0);
    chk("s1_oh0", 32'(round_onehot), 32'b1000);
    drive(0, 0, 1, 3'b000, 0);
    chk("s1_oh1", 32'(round_onehot), 32'b0001);
    drive(0, 0, 1, 3'b011, 0);
    chk("s1_oh2", 32'(round_onehot), 32'b0100);
    drive(0, 1, 0, '0, 0);
    chk("s1_rv",     32'(result_valid), 32'h1);
    chk("s1_total",  32'(total_yes),    32'd5);
    chk("s1_rounds", 32'(rounds),       32'd3);
    chk("s1_maj",    32'(majority),     32'h1);
`ifdef VOTE_TALLY_TIE_FLAG_EN
    chk("s1_tie",    32'(tie),          32'h0);
`endif
    drive(0, 0, 0, '0, 0);
    chk("s1_rv_off", 32'(result_valid), 32'h0);
    chk("s1_held",   32'(majority),     32'h1);

    // four 001 ballots: auto close, fifth offer refused
    drive(1, 0, 0, '0, 0);
    for (int i = 0; i < MR; i++) drive(0, 0, 1, 3'b001, 0);
    chk("s2_rv",     32'(result_valid), 32'h1);
    chk("s2_total",  32'(total_yes),    32'd4);
    chk("s2_rounds", 32'(rounds),       32'd4);
    chk("s2_maj",    32'(majority),     32'h0);
    chk("s2_ready",  32'(ballot_ready), 32'h0);
    drive(0, 0, 1, 3'b001, 0);
    chk("s2_total5", 32'(total_yes),    32'd4);
    chk("s2_busy",   32'(busy),         32'h0);

    // ballot and close together
    drive(1, 0, 0, '0, 0);
    drive(0, 1, 1, 3'b110, 0);
    chk("s3_rv",     32'(result_valid), 32'h1);
    chk("s3_total",  32'(total_yes),    32'd2);
    chk("s3_rounds", 32'(rounds),       32'd1);
    chk("s3_maj",    32'(majority),     32'h1);
    drive(0, 0, 0, '0, 0);

    // exact tie
    drive(1, 0, 0, '0, 0);
    drive(0, 0, 1, 3'b111, 0);
    drive(0, 0, 1, 3'b000, 0);
    drive(0, 1, 0, '0, 0);
    chk("s4_total",  32'(total_yes), 32'd3);
    chk("s4_rounds", 32'(rounds),    32'd2);
    chk("s4_maj",    32'(majority),  32'h0);
`ifdef VOTE_TALLY_TIE_FLAG_EN
    chk("s4_tie",    32'(tie),       32'h1);
`endif
    drive(0, 0, 0, '0, 0);

    // close and ballot in IDLE are ignored
    drive(0, 1, 1, 3'b111, 0);
    chk("idle_busy",  32'(busy),      32'h0);
    chk("idle_total", 32'(total_yes), 32'd3);

    // start while collecting is ignored, ballot still counted
    drive(1, 0, 0, '0, 0);
    drive(0, 0, 1, 3'b111, 0);
    drive(1, 0, 1, 3'b001, 0);
    chk("s5_total",  32'(total_yes), 32'd4);
    chk("s5_rounds", 32'(rounds),    32'd2);
    drive(0, 1, 0, '0, 0);
    chk("s5_maj",    32'(majority),  32'h1);
    drive(0, 0, 0, '0, 0);

    // empty session
    drive(1, 0, 0, '0, 0);
    drive(0, 1, 0, '0, 0);
    chk("s6_rv",  32'(result_valid), 32'h1);
    chk("s6_maj", 32'(majority),     32'h0);
`ifdef VOTE_TALLY_TIE_FLAG_EN
    chk("s6_tie", 32'(tie),          32'h0);
`endif
    drive(0, 0, 0, '0, 0);

    // reset mid-session
    drive(1, 0, 0, '0, 0);
    drive(0, 0, 1, 3'b111, 0);
    drive(0, 0, 0, '0, 1);
    chk("s7_busy",  32'(busy),         32'h0);
    chk("s7_total", 32'(total_yes),    32'h0);
    chk("s7_rv",    32'(result_valid), 32'h0);
    chk("s7_oh",    32'(round_onehot), 32'h1);
    repeat (3) drive(0, 0, 0, '0, 0);
    chk("s7_rv_later", 32'(result_valid), 32'h0);

    @(posedge clk);
    #2;
    report();
    $finish;
  end

endmodule
